cb_multi: RTL and testbench

- Clocked, parametrised successor of the two-way branch cell in the DDP join/branch fabric.
- Takes one token (data word plus destination select) from an upstream four-phase Send/Ack channel.
- Steers the token to one of NUM_OUT downstream channels, or broadcasts it to all of them.
- Completes the upstream handshake only after every addressed consumer has acknowledged.
- Counts tokens with an invalid destination, which are dropped.

---
 rtl/cb_multi.sv | 102 ++++++++++
 tb/tb_cb_multi.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cb_multi.sv
// Clocked N-way branch cell. It captures one upstream token and steers it to one
// output channel or to all of them. Tokens with an invalid destination are dropped and counted.
module cb_multi #(
    parameter int NUM_OUT = 4,
    parameter int DATA_W  = 16,
    parameter int SEL_W   = $clog2(NUM_OUT),
    parameter int CNT_W   = 8
) (
    input  logic               CLK,
    input  logic               MR_n,
    input  logic               Send_in,
    input  logic [DATA_W-1:0]  Data_in,
    input  logic [SEL_W-1:0]   Sel_in,
    input  logic               Bcast_in,
    output logic               Ack_out,
    output logic [NUM_OUT-1:0] Send_out,
    output logic [DATA_W-1:0]  Data_out,
    input  logic [NUM_OUT-1:0] Ack_in,
    output logic               CP,
    output logic               Busy,
    output logic [CNT_W-1:0]   Drop_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]         state;
    logic [NUM_OUT-1:0] mask;
    logic [DATA_W-1:0]  data_q;
    logic [NUM_OUT-1:0] load_mask;
    logic               sel_ok;
    logic               all_acked;
    logic               none_acked;

    always_comb begin
        sel_ok    = (32'(Sel_in) < NUM_OUT);
        load_mask = '0;
        if (Bcast_in)
            load_mask = '1;
        else if (sel_ok)
            load_mask = {{(NUM_OUT-1){1'b0}}, 1'b1} << Sel_in;
    end

    // Ack bits outside the addressed mask never influence completion or release.
    assign all_acked  = ((Ack_in & mask) == mask);
    assign none_acked = ((Ack_in & mask) == '0);
    assign Busy       = (state != IDLE);
    assign Data_out   = data_q;

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            state    <= IDLE;
            mask     <= '0;
            data_q   <= '0;
            Ack_out  <= 1'b0;
            Send_out <= '0;
            CP       <= 1'b0;
            Drop_cnt <= '0;
        end else begin
            CP <= 1'b0;
            case (state)
                IDLE: begin
                    if (Send_in) begin
                        data_q <= Data_in;
                        mask   <= load_mask;
                        CP     <= 1'b1;
                        if (load_mask != '0) begin
                            state    <= SEND;
                            Send_out <= load_mask;
                        end else begin
                            // Dropped token: skip SEND and acknowledge upstream directly.
                            state   <= RELEASE;
                            Ack_out <= 1'b1;
                            if (Drop_cnt != {CNT_W{1'b1}})
                                Drop_cnt <= Drop_cnt + CNT_W'(1);
                        end
                    end
                end
                SEND: begin
                    if (all_acked) begin
                        state    <= RELEASE;
                        Send_out <= '0;
                        Ack_out  <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!Send_in && none_acked) begin
                        state   <= IDLE;
                        Ack_out <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    Send_out <= '0;
                    Ack_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cb_multi.sv
// Directed bench for cb_multi. It drives a 4-way instance through table-driven tokens and
// handshake corner cases, and a 3-way instance through drops and counter saturation.
module tb_cb_multi;

    logic        clk;
    logic        rst4, send4, bcast4, ack_out4, cp4, busy4;
    logic [15:0] data4, data_out4;
    logic [1:0]  sel4;
    logic [3:0]  send_out4, ack_in4;
    logic [7:0]  drop4;

    logic        rst3, send3, bcast3, ack_out3, cp3, busy3;
    logic [15:0] data3, data_out3;
    logic [1:0]  sel3;
    logic [2:0]  send_out3, ack_in3;
    logic [7:0]  drop3;

    int nvec  = 0;
    int nfail = 0;
    int cp_cnt = 0;

    cb_multi #(.NUM_OUT(4), .DATA_W(16), .CNT_W(8)) u4 (
        .CLK(clk), .MR_n(rst4), .Send_in(send4), .Data_in(data4), .Sel_in(sel4),
        .Bcast_in(bcast4), .Ack_out(ack_out4), .Send_out(send_out4), .Data_out(data_out4),
        .Ack_in(ack_in4), .CP(cp4), .Busy(busy4), .Drop_cnt(drop4)
    );

    cb_multi #(.NUM_OUT(3), .DATA_W(16), .CNT_W(8)) u3 (
        .CLK(clk), .MR_n(rst3), .Send_in(send3), .Data_in(data3), .Sel_in(sel3),
        .Bcast_in(bcast3), .Ack_out(ack_out3), .Send_out(send_out3), .Data_out(data_out3),
        .Ack_in(ack_in3), .CP(cp3), .Busy(busy3), .Drop_cnt(drop3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (cp4) cp_cnt++;

    typedef struct {
        logic        bcast;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [3:0]  exp_mask;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'd0, 16'h1234, 4'b0001};
        vecs[1] = '{1'b0, 2'd1, 16'h0F0F, 4'b0010};
        vecs[2] = '{1'b0, 2'd2, 16'hA5A5, 4'b0100};
        vecs[3] = '{1'b0, 2'd3, 16'hFFFF, 4'b1000};
        vecs[4] = '{1'b1, 2'd1, 16'h5A5A, 4'b1111};

        rst4 = 0; send4 = 0; bcast4 = 0; data4 = 0; sel4 = 0; ack_in4 = 0;
        rst3 = 0; send3 = 0; bcast3 = 0; data3 = 0; sel3 = 0; ack_in3 = 0;
        #12;
        chk("reset send_out", 32'(send_out4), 0);
        chk("reset ack_out",  32'(ack_out4), 0);
        chk("reset busy",     32'(busy4), 0);
        chk("reset drop_cnt", 32'(drop4), 0);
        chk("reset data_out", 32'(data_out4), 0);
        rst4 = 1; rst3 = 1;
        tick();

        // Table-driven single-shot tokens, acks returned the cycle Send_out is seen.
        for (int i = 0; i < 5; i++) begin
            send4 = 1; bcast4 = vecs[i].bcast; sel4 = vecs[i].sel; data4 = vecs[i].data;
            tick();
            chk($sformatf("v%0d cp", i),       32'(cp4), 1);
            chk($sformatf("v%0d send_out", i), 32'(send_out4), 32'(vecs[i].exp_mask));
            chk($sformatf("v%0d data_out", i), 32'(data_out4), 32'(vecs[i].data));
            chk($sformatf("v%0d ack_out0", i), 32'(ack_out4), 0);
            data4 = 16'hDEAD;
            ack_in4 = vecs[i].exp_mask;
            tick();
            chk($sformatf("v%0d ack_out1", i), 32'(ack_out4), 1);
            chk($sformatf("v%0d send_off", i), 32'(send_out4), 0);
            chk($sformatf("v%0d data_hold", i), 32'(data_out4), 32'(vecs[i].data));
            send4 = 0; ack_in4 = 0; bcast4 = 0;
            tick();
            chk($sformatf("v%0d idle ack", i),  32'(ack_out4), 0);
            chk($sformatf("v%0d idle busy", i), 32'(busy4), 0);
        end

        // Channel 2 ack arrives three cycles late.
        send4 = 1; sel4 = 2; data4 = 16'hA5A5;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("late send_out", 32'(send_out4), 32'h4);
            chk("late ack_out",  32'(ack_out4), 0);
            tick();
        end
        ack_in4 = 4'b0100;
        tick();
        chk("late ack_out1", 32'(ack_out4), 1);
        chk("late send_off", 32'(send_out4), 0);
        send4 = 0; ack_in4 = 0;
        tick();

        // Broadcast, acks arriving on channels 0,3,1,2 one per cycle.
        send4 = 1; bcast4 = 1;
        tick();
        chk("bc send_out", 32'(send_out4), 32'hF);
        ack_in4 = 4'b0001; tick();
        chk("bc hold a", 32'(send_out4), 32'hF);
        ack_in4 = 4'b1001; tick();
        chk("bc hold b", 32'(send_out4), 32'hF);
        ack_in4 = 4'b1011; tick();
        chk("bc hold c",  32'(send_out4), 32'hF);
        chk("bc no ack",  32'(ack_out4), 0);
        ack_in4 = 4'b1111; tick();
        chk("bc ack_out", 32'(ack_out4), 1);
        chk("bc send_off", 32'(send_out4), 0);
        send4 = 0; bcast4 = 0; ack_in4 = 0;
        tick();

        // Send_in held high long after completion: exactly one capture.
        cp_cnt = 0;
        send4 = 1; sel4 = 1;
        tick();
        ack_in4 = 4'b0010;
        tick();
        chk("hold ack_out", 32'(ack_out4), 1);
        ack_in4 = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold ack stays", 32'(ack_out4), 1);
        end
        send4 = 0;
        tick();
        chk("hold release ack", 32'(ack_out4), 0);
        chk("hold one cp",      32'(cp_cnt), 1);
        send4 = 1; sel4 = 0; data4 = 16'h0BEE;
        tick();
        chk("hold new cp",   32'(cp4), 1);
        chk("hold new send", 32'(send_out4), 32'h1);
        ack_in4 = 4'b0001; tick();
        send4 = 0; ack_in4 = 0; tick();

        // Asynchronous reset while in SEND; held Send_in is recaptured after release.
        send4 = 1; sel4 = 1; data4 = 16'h7777;
        tick();
        chk("rst pre send", 32'(send_out4), 32'h2);
        #2 rst4 = 0;
        #1;
        chk("rst send_out", 32'(send_out4), 0);
        chk("rst busy",     32'(busy4), 0);
        chk("rst data_out", 32'(data_out4), 0);
        chk("rst ack_out",  32'(ack_out4), 0);
        #2 rst4 = 1;
        tick();
        chk("rst recapture cp",   32'(cp4), 1);
        chk("rst recapture send", 32'(send_out4), 32'h2);
        chk("rst recapture data", 32'(data_out4), 32'h7777);
        ack_in4 = 4'b0010; tick();
        send4 = 0; ack_in4 = 0; tick();

        // Foreign ack toggling on channel 1 while addressed to channel 0.
        send4 = 1; sel4 = 0;
        tick();
        for (int c = 0; c < 4; c++) begin
            ack_in4 = (c % 2 == 0) ? 4'b0010 : 4'b0000;
            tick();
            chk("foreign send_out", 32'(send_out4), 32'h1);
            chk("foreign no ack",   32'(ack_out4), 0);
        end
        ack_in4 = 4'b0001; tick();
        chk("foreign done", 32'(ack_out4), 1);
        send4 = 0; ack_in4 = 0; tick();
        chk("drop4 untouched", 32'(drop4), 0);

        // 3-way instance: Sel_in=3 is invalid and gets dropped.
        send3 = 1; sel3 = 3; data3 = 16'h3333;
        tick();
        chk("drop cp",       32'(cp3), 1);
        chk("drop send_out", 32'(send_out3), 0);
        chk("drop ack_out",  32'(ack_out3), 1);
        chk("drop cnt1",     32'(drop3), 1);
        send3 = 0;
        tick();
        chk("drop idle", 32'(busy3), 0);
        for (int n = 1; n < 300; n++) begin
            send3 = 1; tick();
            send3 = 0; tick();
            if (n == 254) chk("drop cnt255", 32'(drop3), 255);
        end
        chk("drop saturate", 32'(drop3), 255);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
